// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and data ports.
// Serialises requests, stalls the loser, bounds fetch starvation, times out.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   if_req/if_addr       fetch request in; if_data/if_stall out
//   dm_read/dm_write     data request in; dm_addr/dm_wdata in
//   dm_rdata/dm_stall    data read result and stall out
//   mem_req/we/addr/wdata registered memory request out
//   mem_rdata/mem_ack    memory response in
//   bus_err              sticky timeout flag, cleared only by rst
module mem_port_arbiter #(
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_stall,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, SRV_D, SRV_I, DONE_D, DONE_I
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] starve_cnt;
    logic [7:0]    wait_cnt;
    logic          dm_any;
    logic          starved;
    logic          grant_d;
    logic          grant_i;
    logic          timeout;

    assign dm_any  = dm_read | dm_write;
    assign starved = if_req & (starve_cnt == SW'(STARVE_MAX));
    assign grant_d = dm_any & ~starved;
    assign grant_i = if_req & ~grant_d;
    // Abort on the edge that ends the TIMEOUT_CYC-th unacknowledged SRV cycle.
    assign timeout = ~mem_ack & (wait_cnt == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_d)      state_nx = SRV_D;
                else if (grant_i) state_nx = SRV_I;
            end
            SRV_D:  if (mem_ack || timeout) state_nx = DONE_D;
            SRV_I:  if (mem_ack || timeout) state_nx = DONE_I;
            DONE_D: state_nx = IDLE;
            DONE_I: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        if_stall = if_req & (state != DONE_I);
        dm_stall = dm_any & (state != DONE_D);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_data    <= '0;
            dm_rdata   <= '0;
            bus_err    <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_write;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (grant_i) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                    if (!if_req || grant_i)
                        starve_cnt <= '0;
                    else if (grant_d && !starved)
                        starve_cnt <= starve_cnt + 1'b1;
                end
                SRV_D, SRV_I: begin
                    if (mem_ack || timeout) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (timeout) bus_err <= 1'b1;
                        // A timed-out read returns zero so the CPU proceeds.
                        if (state == SRV_I)
                            if_data <= timeout ? 32'h0 : mem_rdata;
                        else if (!mem_we)
                            dm_rdata <= timeout ? 32'h0 : mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change and outputs are checked at the falling clock edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_stall;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_data  (if_data),
        .if_stall (if_stall),
        .dm_read  (dm_read),
        .dm_write (dm_write),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_stall (dm_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .bus_err  (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic exp_we;
        rst = 1'b1;
        if_req = 0; if_addr = 0;
        dm_read = 0; dm_write = 0; dm_addr = 0; dm_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        tick();
        tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // 1: fetch only, zero-wait memory
        if_req = 1; if_addr = 32'h10;
        tick();
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_we", 32'(mem_we), 32'd0);
        chk("t1_stall_c1", 32'(if_stall), 32'd1);
        mem_ack = 1; mem_rdata = 32'h20080005;
        tick();
        chk("t1_stall_c2", 32'(if_stall), 32'd0);
        chk("t1_if_data", if_data, 32'h20080005);
        chk("t1_req_drop", 32'(mem_req), 32'd0);
        if_req = 0; mem_ack = 0;
        tick();

        // 2: simultaneous fetch and data read; data first
        if_req = 1; if_addr = 32'h100;
        dm_read = 1; dm_addr = 32'h200;
        tick();
        chk("t2_d_addr", mem_addr, 32'h200);
        chk("t2_if_stall_a", 32'(if_stall), 32'd1);
        chk("t2_dm_stall_a", 32'(dm_stall), 32'd1);
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        chk("t2_dm_stall_b", 32'(dm_stall), 32'd0);
        chk("t2_dm_rdata", dm_rdata, 32'h11111111);
        chk("t2_if_stall_b", 32'(if_stall), 32'd1);
        dm_read = 0; mem_ack = 0;
        tick();
        chk("t2_idle_req", 32'(mem_req), 32'd0);
        chk("t2_if_stall_c", 32'(if_stall), 32'd1);
        tick();
        chk("t2_i_addr", mem_addr, 32'h100);
        chk("t2_i_req", 32'(mem_req), 32'd1);
        chk("t2_if_stall_d", 32'(if_stall), 32'd1);
        mem_ack = 1; mem_rdata = 32'h22222222;
        tick();
        chk("t2_if_stall_e", 32'(if_stall), 32'd0);
        chk("t2_if_data", if_data, 32'h22222222);
        if_req = 0; mem_ack = 0;
        tick();

        // 6: read+write together is a write
        dm_read = 1; dm_write = 1;
        dm_addr = 32'h500; dm_wdata = 32'hA5A5A5A5;
        tick();
        chk("t6_mem_we", 32'(mem_we), 32'd1);
        chk("t6_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("t6_mem_addr", mem_addr, 32'h500);
        mem_ack = 1; mem_rdata = 32'h99999999;
        tick();
        chk("t6_dm_stall", 32'(dm_stall), 32'd0);
        chk("t6_dm_rdata", dm_rdata, 32'h11111111);
        dm_read = 0; dm_write = 0; mem_ack = 0;
        tick();

        // 3: continuous writes with pending fetch: D,D,D,D,I,D
        if_req = 1; if_addr = 32'h40;
        dm_write = 1; dm_addr = 32'h80; dm_wdata = 32'hCAFE0001;
        mem_ack = 1; mem_rdata = 32'h55555555;
        for (int g = 0; g < 6; g++) begin
            exp_we = (g != 4);
            tick();
            chk($sformatf("t3_req_g%0d", g), 32'(mem_req), 32'd1);
            chk($sformatf("t3_we_g%0d", g), 32'(mem_we), 32'(exp_we));
            chk($sformatf("t3_addr_g%0d", g), mem_addr,
                exp_we ? 32'h80 : 32'h40);
            tick();
            chk($sformatf("t3_ifst_g%0d", g), 32'(if_stall),
                32'(exp_we));
            tick();
        end
        chk("t3_dm_rdata", dm_rdata, 32'h11111111);
        if_req = 0; dm_write = 0; mem_ack = 0;
        tick();

        // 4: memory never acks; timeout after 8 SRV cycles
        dm_read = 1; dm_addr = 32'h300;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_req_c%0d", i), 32'(mem_req), 32'd1);
            chk($sformatf("t4_err_c%0d", i), 32'(bus_err), 32'd0);
            tick();
        end
        chk("t4_req_drop", 32'(mem_req), 32'd0);
        chk("t4_bus_err", 32'(bus_err), 32'd1);
        chk("t4_dm_rdata", dm_rdata, 32'h0);
        chk("t4_dm_stall_lo", 32'(dm_stall), 32'd0);
        tick();
        chk("t4_dm_stall_hi", 32'(dm_stall), 32'd1);
        dm_read = 0;
        tick();
        chk("t4_err_sticky", 32'(bus_err), 32'd1);

        // 5: async reset in SRV_D after 3 wait cycles
        dm_read = 1; dm_addr = 32'h400;
        tick();
        tick();
        tick();
        tick();
        chk("t5_req_pre", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_req_async", 32'(mem_req), 32'd0);
        chk("t5_err_clr", 32'(bus_err), 32'd0);
        chk("t5_addr_clr", mem_addr, 32'h0);
        chk("t5_if_data", if_data, 32'h0);
        chk("t5_dm_rdata", dm_rdata, 32'h0);
        dm_read = 0;
        tick();
        rst = 1'b0;
        dm_read = 1; dm_addr = 32'h600;
        tick();
        chk("t5_post_req", 32'(mem_req), 32'd1);
        chk("t5_post_addr", mem_addr, 32'h600);
        mem_ack = 1; mem_rdata = 32'h44444444;
        tick();
        chk("t5_post_data", dm_rdata, 32'h44444444);
        dm_read = 0; mem_ack = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
